// File: rtl/spu_pipe_ctrl.sv
// spu_pipe_ctrl: flow controller for a fixed-latency, cke-gated SPU datapath.
// Turns the valid/ready handshakes at the chain boundary into one global cke,
// tracks in-flight tokens with a valid shift register, and presents results on
// a valid/ready master port. The input 'reset' is asynchronous and active-low.
// 'flush' is a synchronous discard of every in-flight and buffered token.
// Optional feature: define SPU_PIPE_CTRL_SKID_EN to add a 2-entry output FIFO.
// That removes the combinational m_ready -> cke path and adds one cycle of latency.
module spu_pipe_ctrl #(
    parameter int LATENCY   = 1,
    parameter int DATA_BITS = 8,
    parameter int CNT_BITS  = $clog2(LATENCY + 3)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic                 cke,
    input  logic [DATA_BITS-1:0] dp_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DATA_BITS-1:0] m_data,
    output logic [CNT_BITS-1:0]  count,
    output logic                 busy
);

    if (LATENCY < 1) begin : g_latency_check
        $error("spu_pipe_ctrl: LATENCY must be >= 1");
    end

    logic [LATENCY-1:0]   vld_q, vld_d;
    logic [CNT_BITS-1:0]  count_q, count_d;
    logic                 busy_q;
    logic                 cke_s;
    logic                 accept_s;
    logic                 xfer_s;
    logic                 m_valid_s;
    logic [DATA_BITS-1:0] m_data_s;

`ifdef SPU_PIPE_CTRL_SKID_EN
    logic [1:0]           fifo_cnt_q, fifo_cnt_d;
    logic [DATA_BITS-1:0] fifo0_q, fifo0_d;
    logic [DATA_BITS-1:0] fifo1_q, fifo1_d;
    logic                 push_s;
    logic                 pop_s;

    // Skid mode: cke depends only on registered FIFO occupancy; the head entry drives the output port.
    always_comb begin
        cke_s     = (fifo_cnt_q < 2'd2);
        m_valid_s = (fifo_cnt_q != 2'd0);
        if (m_valid_s) begin
            m_data_s = fifo0_q;
        end else begin
            m_data_s = '0;
        end
        push_s = vld_q[LATENCY-1] && cke_s && !flush;
        pop_s  = m_valid_s && m_ready && !flush;
        xfer_s = pop_s;
    end

    // Next state of the 2-entry FIFO. Entry 0 is always the head, and a pop shifts entry 1 forward.
    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        fifo0_d    = fifo0_q;
        fifo1_d    = fifo1_q;
        if (flush) begin
            fifo_cnt_d = 2'd0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (fifo_cnt_q == 2'd0) begin
                        fifo0_d = dp_data;
                    end else begin
                        fifo1_d = dp_data;
                    end
                    fifo_cnt_d = fifo_cnt_q + 2'd1;
                end
                2'b01: begin
                    fifo0_d    = fifo1_q;
                    fifo_cnt_d = fifo_cnt_q - 2'd1;
                end
                2'b11: begin
                    if (fifo_cnt_q == 2'd1) begin
                        fifo0_d = dp_data;
                    end else begin
                        fifo0_d = fifo1_q;
                        fifo1_d = dp_data;
                    end
                end
                default: begin
                    fifo_cnt_d = fifo_cnt_q;
                end
            endcase
        end
    end

    // FIFO storage and occupancy registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_cnt_q <= 2'd0;
            fifo0_q    <= '0;
            fifo1_q    <= '0;
        end else begin
            fifo_cnt_q <= fifo_cnt_d;
            fifo0_q    <= fifo0_d;
            fifo1_q    <= fifo1_d;
        end
    end
`else
    // Base mode: the last valid bit is the output valid. A stalled output freezes the whole chain through cke.
    always_comb begin
        m_valid_s = vld_q[LATENCY-1];
        cke_s     = !vld_q[LATENCY-1] || m_ready;
        if (m_valid_s) begin
            m_data_s = dp_data;
        end else begin
            m_data_s = '0;
        end
        xfer_s = m_valid_s && m_ready && !flush;
    end
`endif

    // Valid shift register. It advances with cke, holds otherwise, and clears on flush.
    always_comb begin
        accept_s = s_valid && cke_s && !flush;
        vld_d    = vld_q;
        if (flush) begin
            vld_d = '0;
        end else if (cke_s) begin
            vld_d[0] = s_valid;
            for (int i = 1; i < LATENCY; i++) begin
                vld_d[i] = vld_q[i-1];
            end
        end else begin
            vld_d = vld_q;
        end
    end

    // Occupancy counter. An accept adds one, an output transfer removes one, and flush clears it.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            case ({accept_s, xfer_s})
                2'b10:   count_d = count_q + CNT_BITS'(1);
                2'b01:   count_d = count_q - CNT_BITS'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Token-tracking state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q   <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            vld_q   <= vld_d;
            count_q <= count_d;
            busy_q  <= (count_d != '0);
        end
    end

    assign cke     = cke_s;
    assign s_ready = cke_s;
    assign m_valid = m_valid_s;
    assign m_data  = m_data_s;
    assign count   = count_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_spu_pipe_ctrl.sv
// Scoreboard bench for spu_pipe_ctrl. It models the external cke-gated
// datapath, pushes every accepted token into an expected queue, and
// a negedge monitor compares outputs against the queue head.
module tb_spu_pipe_ctrl;

    localparam int LAT = 3;
    localparam int DW  = 8;
    localparam int CW  = $clog2(LAT + 3);
`ifdef SPU_PIPE_CTRL_SKID_EN
    localparam int EXP_LAT = LAT + 1;
    localparam int MAX_CNT = LAT + 2;
`else
    localparam int EXP_LAT = LAT;
    localparam int MAX_CNT = LAT;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          cke;
    logic [DW-1:0] dp_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic [CW-1:0] count;
    logic          busy;
    logic [DW-1:0] s_data = '0;

    int compared   = 0;
    int mismatched = 0;
    logic mon_en   = 1'b0;
    logic [DW-1:0] exp_q[$];

    spu_pipe_ctrl #(.LATENCY(LAT), .DATA_BITS(DW)) dut (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .cke     (cke),
        .dp_data (dp_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .count   (count),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // External datapath: LAT registers, all enabled by cke, never reset.
    logic [DW-1:0] dp_pipe [LAT];
    initial for (int i = 0; i < LAT; i++) dp_pipe[i] = '0;
    always @(posedge clk) begin
        if (cke) begin
            dp_pipe[0] <= s_data;
            for (int i = 1; i < LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
        end
    end
    assign dp_data = dp_pipe[LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: checks occupancy against the scoreboard and pops on every output transfer.
    always @(negedge clk) begin
        if (mon_en && reset) begin
            chk("count", 32'(count), 32'(exp_q.size()));
            chk("busy", 32'(busy), 32'(exp_q.size() != 0));
            chk("s_ready_eq_cke", 32'(s_ready), 32'(cke));
            chk("count_bound", 32'(int'(count) <= MAX_CNT), 32'd1);
`ifndef SPU_PIPE_CTRL_SKID_EN
            chk("cke_rule", 32'(cke), 32'(!m_valid || m_ready));
`endif
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_m_valid", 32'd1, 32'd0);
                end else begin
                    chk("m_data", 32'(m_data), 32'(exp_q[0]));
                    if (m_ready && !flush) void'(exp_q.pop_front());
                end
            end else begin
                chk("m_data_idle", 32'(m_data), 32'd0);
            end
        end
    end

    // One cycle of stimulus. The accepted token is pushed into the scoreboard after the monitor sample.
    task automatic step(input logic sv, input logic mr, input logic fl);
        @(posedge clk);
        #1;
        s_valid = sv;
        s_data  = DW'($urandom);
        m_ready = mr;
        flush   = fl;
        @(negedge clk);
        #1;
        if (flush) exp_q.delete();
        else if (s_valid && s_ready) exp_q.push_back(s_data);
    endtask

    initial begin
        int lat_seen;
        int first_v;
        int vcnt;
        int peak;

        // Reset state while reset is held low.
        repeat (3) @(posedge clk);
        #2;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_cke", 32'(cke), 32'd1);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        mon_en = 1'b1;

        // Single-token latency from an idle pipe.
        lat_seen = -1;
        step(1'b1, 1'b1, 1'b0);
        for (int n = 1; n <= 20; n++) begin
            step(1'b0, 1'b1, 1'b0);
            if (m_valid && lat_seen < 0) lat_seen = n;
        end
        chk("latency", 32'(lat_seen), 32'(EXP_LAT));

        // Three back-to-back tokens with m_ready high.
        first_v = -1; vcnt = 0; peak = 0;
        for (int n = 0; n < 14; n++) begin
            step(n < 3, 1'b1, 1'b0);
            if (m_valid) begin
                vcnt++;
                if (first_v < 0) first_v = n;
            end
            if (int'(count) > peak) peak = int'(count);
        end
        chk("abc_first_valid", 32'(first_v), 32'(EXP_LAT));
        chk("abc_valid_cycles", 32'(vcnt), 32'd3);
        chk("abc_peak_count", 32'(peak), 32'd3);

        // Continuous s_valid while m_ready is low: the pipe fills and cke stalls.
        for (int n = 0; n < 10; n++) step(1'b1, 1'b0, 1'b0);
        chk("stall_count", 32'(count), 32'(MAX_CNT));
        chk("stall_cke", 32'(cke), 32'd0);
        chk("stall_s_ready", 32'(s_ready), 32'd0);
        chk("stall_m_valid", 32'(m_valid), 32'd1);
        step(1'b0, 1'b1, 1'b0);
`ifdef SPU_PIPE_CTRL_SKID_EN
        chk("first_pop_cke", 32'(cke), 32'd0);
        step(1'b0, 1'b1, 1'b0);
        chk("after_pop_cke", 32'(cke), 32'd1);
`else
        chk("release_cke", 32'(cke), 32'd1);
`endif
        for (int n = 0; n < LAT + 6; n++) step(1'b0, 1'b1, 1'b0);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        // Flush with three tokens held and a new token presented in the same cycle.
        for (int n = 0; n < 3; n++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        chk("pre_flush_count", 32'(count), 32'd3);
        step(1'b0, 1'b1, 1'b0);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_m_valid", 32'(m_valid), 32'd0);
        chk("flush_busy", 32'(busy), 32'd0);
        for (int n = 0; n < LAT + 4; n++) step(1'b0, 1'b1, 1'b0);

        // Random traffic with occasional flushes.
        for (int n = 0; n < 400; n++)
            step(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 50) == 0);

        // m_ready toggles every cycle while s_valid stays high.
        for (int n = 0; n < 100; n++) step(1'b1, n[0] == 1'b0, 1'b0);

        // Asynchronous reset mid-operation.
        for (int n = 0; n < LAT + 2; n++) step(1'b1, 1'b1, 1'b0);
        chk("pre_reset_m_valid", 32'(m_valid), 32'd1);
        mon_en = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        chk("async_m_valid", 32'(m_valid), 32'd0);
        chk("async_count", 32'(count), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        exp_q.delete();
        s_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("post_reset_cke", 32'(cke), 32'd1);
        chk("post_reset_s_ready", 32'(s_ready), 32'd1);
        mon_en = 1'b1;

        // Traffic after reset, then a final drain.
        for (int n = 0; n < 60; n++) step(($urandom % 2) != 0, ($urandom % 4) != 0, 1'b0);
        for (int n = 0; n < LAT + 8; n++) step(1'b0, 1'b1, 1'b0);
        chk("final_empty", 32'(exp_q.size()), 32'd0);
        chk("final_count", 32'(count), 32'd0);

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
